// File: rtl/uart_pkg.sv
// Shared UART constants: 8N1 framing and receive FSM state encodings.
// Imported by both the rx and tx sides so the frame format stays in one place.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int CNT_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/fifo.sv
// Shared synchronous FIFO, power-of-two depth.
// Pointers carry one extra wrap bit to tell full from empty.
module fifo #(
  parameter int WIDTH  = 8,
  parameter int LGFLEN = 3
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [LGFLEN:0] ONE = {{LGFLEN{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [0:(1<<LGFLEN)-1];
  logic [LGFLEN:0]  wr_ptr;
  logic [LGFLEN:0]  rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[LGFLEN] != rd_ptr[LGFLEN]) &&
                   (wr_ptr[LGFLEN-1:0] == rd_ptr[LGFLEN-1:0]);

  // A write into a full FIFO is fine when the same edge frees a slot.
  assign wr_en = i_wr && (!o_full || i_rd);
  assign rd_en = i_rd && !o_empty;

  assign o_data = mem[rd_ptr[LGFLEN-1:0]];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_en) rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[LGFLEN-1:0]] <= i_data;
  end

endmodule

// File: rtl/rx_uart.sv
// Serial deframer: synchronizer, mid-bit sampling FSM and shift register.
// Emits a one-cycle push with the byte, or a frame-error strobe.
module rx_uart
  import uart_pkg::*;
#(
  parameter int                  TIMER_BITS      = 32,
  parameter logic [TIMER_BITS-1:0] CLOCKS_PER_BAUD = 868
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 uart_txd_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_push,
  output logic                 o_frame_err
);

  localparam logic [TIMER_BITS-1:0] T_ONE  = TIMER_BITS'(1);
  localparam logic [TIMER_BITS-1:0] T_HALF = (CLOCKS_PER_BAUD >> 1) - T_ONE;
  localparam logic [TIMER_BITS-1:0] T_FULL = CLOCKS_PER_BAUD - T_ONE;
  localparam logic [CNT_W-1:0]      LAST   = CNT_W'(DATA_BITS - 1);

  logic [1:0]           sync;
  logic                 rxs;
  rx_state_e            state;
  logic [TIMER_BITS-1:0] timer;
  logic [CNT_W-1:0]     count;
  logic [DATA_BITS-1:0] shreg;
  logic                 expired;

  assign rxs     = sync[1];
  assign expired = (timer == '0);
  assign o_data  = shreg;

  always_ff @(posedge clk) begin
    if (i_reset) sync <= 2'b11;
    else         sync <= {sync[0], uart_txd_in};
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      count       <= '0;
      shreg       <= '0;
      o_push      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_push      <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            timer <= T_HALF;
          end
        end
        ST_START: begin
          if (!expired) begin
            timer <= timer - T_ONE;
          end else if (rxs) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_DATA;
            timer <= T_FULL;
            count <= '0;
          end
        end
        ST_DATA: begin
          if (!expired) begin
            timer <= timer - T_ONE;
          end else begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            timer <= T_FULL;
            count <= count + CNT_W'(1);
            if (count == LAST) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!expired) begin
            timer <= timer - T_ONE;
          end else if (rxs) begin
            state  <= ST_IDLE;
            o_push <= 1'b1;
          end else begin
            state       <= ST_BREAK;
            o_frame_err <= 1'b1;
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rx.sv
// UART receiver top: deframer feeding an 8-deep FIFO.
// Overrun and frame errors are sticky until cleared.
module rx
  import uart_pkg::*;
#(
  parameter int                    TIMER_BITS      = 32,
  parameter logic [TIMER_BITS-1:0] CLOCKS_PER_BAUD = 868,
  parameter int                    LGFLEN          = 3
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 uart_txd_in,
  input  logic                 i_ready,
  input  logic                 i_clr_err,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_overrun,
  output logic                 o_frame_err
);

  logic [DATA_BITS-1:0] rx_byte;
  logic                 push;
  logic                 ferr;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 ovr;

  rx_uart #(
    .TIMER_BITS      (TIMER_BITS),
    .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
  ) u_uart (
    .clk         (clk),
    .i_reset     (i_reset),
    .uart_txd_in (uart_txd_in),
    .o_data      (rx_byte),
    .o_push      (push),
    .o_frame_err (ferr)
  );

  fifo #(
    .WIDTH  (DATA_BITS),
    .LGFLEN (LGFLEN)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .i_wr    (push),
    .i_data  (rx_byte),
    .i_rd    (pop),
    .o_data  (o_data),
    .o_full  (full),
    .o_empty (empty)
  );

  assign o_valid = !empty;
  assign pop     = o_valid && i_ready;
  assign ovr     = push && full && !pop;

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_overrun   <= ovr  || (o_overrun   && !i_clr_err);
      o_frame_err <= ferr || (o_frame_err && !i_clr_err);
    end
  end

endmodule

// File: tb/tb_rx.sv
// Scoreboard bench for rx at 16 clocks per baud.
// Sent bytes are queued as expected and checked as they are popped.
module tb_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       line;
  logic       i_ready;
  logic       i_clr_err;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_overrun;
  logic       o_frame_err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int start_cyc;
  int first_valid_cyc;
  int hi_cnt;
  int pops_cnt;
  logic valid_q = 1'b0;
  logic [7:0] exp_q[$];

  rx #(
    .TIMER_BITS      (32),
    .CLOCKS_PER_BAUD (32'(CPB)),
    .LGFLEN          (3)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .uart_txd_in (line),
    .i_ready     (i_ready),
    .i_clr_err   (i_clr_err),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_overrun   (o_overrun),
    .o_frame_err (o_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid && !valid_q) first_valid_cyc = cyc;
    valid_q = o_valid;
    if (o_valid) hi_cnt++;
    if (!i_reset && o_valid && i_ready) begin
      pops_cnt++;
      check("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("data", o_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    line = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (CPB) tick();
    end
    line = stop;
    repeat (CPB) tick();
  endtask

  task automatic drain();
    i_ready = 1'b1;
    repeat (12) tick();
    i_ready = 1'b0;
  endtask

  initial begin
    i_reset   = 1'b1;
    line      = 1'b1;
    i_ready   = 1'b0;
    i_clr_err = 1'b0;
    tick();
    tick();
    check("rst_valid", o_valid, 0);
    check("rst_ovr", o_overrun, 0);
    check("rst_ferr", o_frame_err, 0);
    i_reset = 1'b0;
    repeat (4) tick();

    // single byte, latency from start edge to o_valid
    i_ready = 1'b1;
    hi_cnt = 0;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    repeat (10) tick();
    check("a5_latency", first_valid_cyc - start_cyc, 156);
    check("a5_valid_len", hi_cnt, 1);
    check("a5_ovr", o_overrun, 0);
    check("a5_ferr", o_frame_err, 0);

    // nine bytes into an 8-deep FIFO with no consumer
    i_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'(i));
      send(8'(i), 1'b1);
    end
    tick();
    check("ovr_set", o_overrun, 1);
    check("ovr_valid", o_valid, 1);
    pops_cnt = 0;
    drain();
    check("ovr_drained", pops_cnt, 8);
    check("ovr_empty", o_valid, 0);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("ovr_clr", o_overrun, 0);

    // short low glitch rejected
    line = 1'b0;
    repeat (4) tick();
    line = 1'b1;
    repeat (30) tick();
    check("glitch_valid", o_valid, 0);
    check("glitch_ferr", o_frame_err, 0);
    i_ready = 1'b1;
    pops_cnt = 0;
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    repeat (5) tick();
    check("glitch_next", pops_cnt, 1);

    // low stop bit: break, no push
    send(8'h55, 1'b0);
    repeat (24) tick();
    line = 1'b1;
    repeat (4) tick();
    check("fe_set", o_frame_err, 1);
    check("fe_valid", o_valid, 0);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("fe_clr", o_frame_err, 0);
    pops_cnt = 0;
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1);
    repeat (5) tick();
    check("fe_next", pops_cnt, 1);

    // clear on the same edge as a new frame error: set wins
    fork
      send(8'h55, 1'b0);
      begin
        repeat (155) tick();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
      end
    join
    line = 1'b1;
    repeat (4) tick();
    check("fe_set_wins", o_frame_err, 1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("fe_clr2", o_frame_err, 0);

    // reset during data bit 4 discards FIFO and frame
    i_ready = 1'b0;
    exp_q.push_back(8'h77);
    send(8'h77, 1'b1);
    tick();
    check("pre_rst_valid", o_valid, 1);
    fork
      send(8'hFF, 1'b1);
      begin
        repeat (88) tick();
        i_reset = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_ovr", o_overrun, 0);
        check("mid_rst_ferr", o_frame_err, 0);
        tick();
        i_reset = 1'b0;
      end
    join
    repeat (20) tick();
    check("post_rst_valid", o_valid, 0);
    i_ready = 1'b1;
    pops_cnt = 0;
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1);
    repeat (5) tick();
    check("post_rst_rx", pops_cnt, 1);

    // full FIFO, consumer ready only on the push edge
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'hC0 + i));
      send(8'(8'hC0 + i), 1'b1);
    end
    tick();
    check("full_valid", o_valid, 1);
    exp_q.push_back(8'hC8);
    pops_cnt = 0;
    fork
      send(8'hC8, 1'b1);
      begin
        repeat (155) tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
      end
    join
    tick();
    check("full_pop", pops_cnt, 1);
    check("full_no_ovr", o_overrun, 0);
    pops_cnt = 0;
    drain();
    check("full_remain", pops_cnt, 8);
    check("full_empty", o_valid, 0);

    check("queue_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rx.md
RX -- requirements
Module: rx

Interface
REQ-001 Parameter TIMER_BITS, default 32, width of the baud timer.
REQ-002 Parameter CLOCKS_PER_BAUD, default 868, clk cycles per bit (>=4), TIMER_BITS wide.
REQ-003 Parameter LGFLEN, default 3, log2 of the receive FIFO depth (8 entries).
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 uart_txd_in  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 i_ready  input  1  consumer accepts o_data when high with o_valid.
REQ-008 i_clr_err  input  1  one-cycle pulse that clears the sticky error flags.
REQ-009 o_valid  output  1  FIFO non-empty; o_data holds the oldest byte.
REQ-010 o_data  output  8  oldest received byte; stable while o_valid is high and no pop occurs.
REQ-011 o_overrun  output  1  sticky; a good byte was dropped because the FIFO was full.
REQ-012 o_frame_err  output  1  sticky; a stop bit was sampled low.

Function
REQ-013 uart_txd_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use; the synchronized signal is called rxs.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK.
REQ-015 IDLE -> START when rxs is 0; the timer loads CLOCKS_PER_BAUD/2 - 1.
REQ-016 START: at timer expiry, rxs=0 -> DATA with the timer at CLOCKS_PER_BAUD-1 and bit count 0; rxs=1 -> IDLE (glitch rejected, nothing written).
REQ-017 DATA: at each timer expiry, shift rxs into bit 7 of the shift register, reload the timer, and increment the count; after the 8th sample -> STOP.
REQ-018 STOP: at timer expiry, rxs=1 -> IDLE with a push request; rxs=0 -> BREAK, set o_frame_err, and discard the byte.
REQ-019 BREAK -> IDLE on the first cycle rxs is 1.
REQ-020 Push SHALL occur on the cycle after the stop sample; o_valid SHALL rise on the following cycle if the FIFO was empty (stop sample at T gives o_valid at T+2).
REQ-021 Pop occurs when o_valid && i_ready; the next byte is presented on the next cycle.
REQ-022 Push while full: accepted if a pop occurs in the same cycle (occupancy unchanged); otherwise the byte is dropped and o_overrun is set.
REQ-023 Simultaneous push and pop on an empty FIFO: the pop is ignored (o_valid is low) and the push is accepted.
REQ-024 FIFO pointers SHALL be LGFLEN+1 bits and wrap naturally; full = MSBs differ and LSBs are equal; empty = pointers are equal.
REQ-025 i_clr_err clears both flags; a set event in the same cycle as i_clr_err wins (the flag stays 1).
REQ-026 Byte order SHALL be preserved; the first bit received lands in o_data[0].

Reset
REQ-027 On i_reset: FSM -> IDLE; timer, count and shift register -> 0; synchronizer -> 1; FIFO pointers -> 0; o_valid, o_overrun, o_frame_err -> 0.
REQ-028 A reset mid-frame SHALL abandon the frame; after reset, reception resumes on the next falling edge of rxs.

Structure
REQ-029 FSM state encodings (3 bits) and the 8N1 frame constants (data bits 8, stop bits 1) SHALL live in the shared uart package, so the tx side uses the same constants.
REQ-030 The serial deframer SHALL be the sub-module rx_uart (synchronizer, FSM, timer, shift register, push strobe); rx SHALL contain the FIFO and the error flags.
REQ-031 The FIFO SHALL be the existing shared fifo block with width 8 and LGFLEN 3.

Verification (CLOCKS_PER_BAUD=16)
REQ-032 Send 0xA5 with i_ready=1 -> o_valid for 1 cycle, o_data=0xA5 exactly 2 cycles after the stop-bit sample; flags stay 0.
REQ-033 Send 9 bytes 0x00..0x08 back to back with i_ready=0 -> bytes 0x00..0x07 are held, 0x08 is dropped, o_overrun=1; draining yields 0x00..0x07 in order, then o_valid=0.
REQ-034 Pulse the line low for 4 cycles -> FSM returns to IDLE, no push; a following 0x3C is received correctly.
REQ-035 Send 0x55 with the stop bit low, then the line high after 40 cycles -> no push, o_frame_err=1; i_clr_err clears it; the next byte 0x12 is received.
REQ-036 Assert i_reset during data bit 4 of 0xFF -> nothing pushed, outputs are at reset values; the next frame 0x81 is received intact.
REQ-037 FIFO full with i_ready=1 at the push cycle -> the push is accepted, no overrun, and 8 valid bytes remain.
